// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry holding buffer per result producer, and a
// round-robin scheduler that grants up to CDB_PORTS buffered results per cycle onto registered slots.
module cdb_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int CDB_PORTS = 3,
    parameter int REG_SIZE  = 32,
    parameter int NUM_TAGS  = 64,
    parameter int ROB_SIZE  = 64,
    localparam int NUM_TAGS_LOG2 = $clog2(NUM_TAGS),
    localparam int ROB_SIZE_LOG2 = $clog2(ROB_SIZE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     req_valid     [NUM_REQ],
    input  logic [NUM_TAGS_LOG2-1:0] req_tag       [NUM_REQ],
    input  logic [REG_SIZE-1:0]      req_data      [NUM_REQ],
    input  logic [ROB_SIZE_LOG2-1:0] req_rob_index [NUM_REQ],
    output logic                     req_ready     [NUM_REQ],
    output logic                     cdb_valid     [CDB_PORTS],
    output logic [NUM_TAGS_LOG2-1:0] cdb_tags      [CDB_PORTS],
    output logic [REG_SIZE-1:0]      cdb_data      [CDB_PORTS],
    output logic [ROB_SIZE_LOG2-1:0] cdb_rob_index [CDB_PORTS]
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(CDB_PORTS + 1);

    // Handshake: a producer's result transfers in any cycle where req_valid and
    // req_ready are both high; while req_ready is low the producer holds its result.

    logic [NUM_REQ-1:0]       buf_full_q;
    logic [NUM_TAGS_LOG2-1:0] buf_tag_q  [NUM_REQ];
    logic [REG_SIZE-1:0]      buf_data_q [NUM_REQ];
    logic [ROB_SIZE_LOG2-1:0] buf_rob_q  [NUM_REQ];
    logic [PTR_W-1:0]         rr_ptr_q;
    logic [PTR_W-1:0]         rr_ptr_d;

    logic                     cdb_valid_q [CDB_PORTS];
    logic [NUM_TAGS_LOG2-1:0] cdb_tag_q   [CDB_PORTS];
    logic [REG_SIZE-1:0]      cdb_data_q  [CDB_PORTS];
    logic [ROB_SIZE_LOG2-1:0] cdb_rob_q   [CDB_PORTS];

    logic [NUM_REQ-1:0]   granted;
    logic [NUM_REQ-1:0]   accept;
    logic [CDB_PORTS-1:0] slot_vld;
    logic [PTR_W-1:0]     slot_src [CDB_PORTS];
    logic [PTR_W-1:0]     last_idx;
    logic [CNT_W-1:0]     n_grant;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    // Circular scan from rr_ptr; the k-th full buffer found owns slot k.
    always_comb begin
        granted  = '0;
        slot_vld = '0;
        last_idx = rr_ptr_q;
        n_grant  = '0;
        for (int k = 0; k < CDB_PORTS; k++) slot_src[k] = '0;
        for (int o = 0; o < NUM_REQ; o++) begin
            if (buf_full_q[wrap_idx(rr_ptr_q, o)] && (n_grant < CNT_W'(CDB_PORTS))) begin
                granted[wrap_idx(rr_ptr_q, o)] = 1'b1;
                slot_vld[n_grant]              = 1'b1;
                slot_src[n_grant]              = wrap_idx(rr_ptr_q, o);
                last_idx                       = wrap_idx(rr_ptr_q, o);
                n_grant                        = n_grant + CNT_W'(1);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (|granted) begin
            rr_ptr_d = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = rst & ~flush & (~buf_full_q[i] | granted[i]);
            accept[i]    = req_valid[i] & req_ready[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q   <= '0;
            buf_full_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                buf_tag_q[i]  <= '0;
                buf_data_q[i] <= '0;
                buf_rob_q[i]  <= '0;
            end
            for (int k = 0; k < CDB_PORTS; k++) begin
                cdb_valid_q[k] <= 1'b0;
                cdb_tag_q[k]   <= '0;
                cdb_data_q[k]  <= '0;
                cdb_rob_q[k]   <= '0;
            end
        end else if (flush) begin
            rr_ptr_q   <= '0;
            buf_full_q <= '0;
            for (int k = 0; k < CDB_PORTS; k++) begin
                cdb_valid_q[k] <= 1'b0;
                cdb_tag_q[k]   <= '0;
                cdb_data_q[k]  <= '0;
                cdb_rob_q[k]   <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            // A new result wins over draining, so a granted buffer can refill in the same cycle.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    buf_full_q[i] <= 1'b1;
                    buf_tag_q[i]  <= req_tag[i];
                    buf_data_q[i] <= req_data[i];
                    buf_rob_q[i]  <= req_rob_index[i];
                end else if (granted[i]) begin
                    buf_full_q[i] <= 1'b0;
                end
            end
            for (int k = 0; k < CDB_PORTS; k++) begin
                cdb_valid_q[k] <= slot_vld[k];
                cdb_tag_q[k]   <= slot_vld[k] ? buf_tag_q[slot_src[k]]  : '0;
                cdb_data_q[k]  <= slot_vld[k] ? buf_data_q[slot_src[k]] : '0;
                cdb_rob_q[k]   <= slot_vld[k] ? buf_rob_q[slot_src[k]]  : '0;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < CDB_PORTS; k++) begin
            cdb_valid[k]     = cdb_valid_q[k];
            cdb_tags[k]      = cdb_tag_q[k];
            cdb_data[k]      = cdb_data_q[k];
            cdb_rob_index[k] = cdb_rob_q[k];
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a queue-based round-robin reference model.
module tb_cdb_arbiter;

    localparam int NR = 4;
    localparam int NP = 3;
    localparam int DW = 32;
    localparam int TW = 6;
    localparam int RW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          req_valid     [NR];
    logic [TW-1:0] req_tag       [NR];
    logic [DW-1:0] req_data      [NR];
    logic [RW-1:0] req_rob_index [NR];
    logic          req_ready     [NR];
    logic          cdb_valid     [NP];
    logic [TW-1:0] cdb_tags      [NP];
    logic [DW-1:0] cdb_data      [NP];
    logic [RW-1:0] cdb_rob_index [NP];

    cdb_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
        .req_rob_index(req_rob_index), .req_ready(req_ready),
        .cdb_valid(cdb_valid), .cdb_tags(cdb_tags), .cdb_data(cdb_data),
        .cdb_rob_index(cdb_rob_index)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit            m_full [NR];
    logic [TW-1:0] m_tag  [NR];
    logic [DW-1:0] m_data [NR];
    logic [RW-1:0] m_rob  [NR];
    int            m_ptr;
    bit            e_v    [NP];
    logic [TW-1:0] e_tag  [NP];
    logic [DW-1:0] e_data [NP];
    logic [RW-1:0] e_rob  [NP];
    int            order[$];
    bit            obs_ready [NR];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) m_full[i] = 0;
        for (int k = 0; k < NP; k++) begin
            e_v[k] = 0; e_tag[k] = '0; e_data[k] = '0; e_rob[k] = '0;
        end
        m_ptr = 0;
    endfunction

    // Full buffers in circular order from the pointer; the first NP get slots.
    function automatic void model_grants();
        order.delete();
        for (int o = 0; o < NR; o++) begin
            int i;
            i = (m_ptr + o) % NR;
            if (m_full[i] && order.size() < NP) order.push_back(i);
        end
    endfunction

    function automatic bit model_ready(input int i);
        bit g;
        g = 0;
        foreach (order[k]) if (order[k] == i) g = 1;
        return rst && !flush && (!m_full[i] || g);
    endfunction

    task automatic set_req(input int i, input bit v, input int tag, input logic [DW-1:0] data, input int rob);
        req_valid[i]     = v;
        req_tag[i]       = TW'(tag);
        req_data[i]      = data;
        req_rob_index[i] = RW'(rob);
    endtask

    task automatic idle();
        for (int i = 0; i < NR; i++) req_valid[i] = 1'b0;
    endtask

    task automatic chk_cdb_model();
        for (int k = 0; k < NP; k++) begin
            chk($sformatf("cdb_valid[%0d]", k), 64'(cdb_valid[k]), 64'(e_v[k]));
            chk($sformatf("cdb_tags[%0d]", k), 64'(cdb_tags[k]), 64'(e_tag[k]));
            chk($sformatf("cdb_data[%0d]", k), 64'(cdb_data[k]), 64'(e_data[k]));
            chk($sformatf("cdb_rob[%0d]", k), 64'(cdb_rob_index[k]), 64'(e_rob[k]));
        end
    endtask

    // One clock cycle: called at a falling edge with inputs already driven.
    task automatic tick();
        bit g   [NR];
        bit acc [NR];
        #1;
        model_grants();
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("req_ready[%0d]", i), 64'(req_ready[i]), 64'(model_ready(i)));
            obs_ready[i] = req_ready[i];
            g[i] = 0;
        end
        foreach (order[k]) g[order[k]] = 1;
        for (int i = 0; i < NR; i++) acc[i] = req_valid[i] && model_ready(i);
        if (!rst || flush) begin
            model_reset();
        end else begin
            for (int k = 0; k < NP; k++) begin
                if (k < order.size()) begin
                    e_v[k] = 1; e_tag[k] = m_tag[order[k]];
                    e_data[k] = m_data[order[k]]; e_rob[k] = m_rob[order[k]];
                end else begin
                    e_v[k] = 0; e_tag[k] = '0; e_data[k] = '0; e_rob[k] = '0;
                end
            end
            if (order.size() > 0) m_ptr = (order[$] + 1) % NR;
            for (int i = 0; i < NR; i++) begin
                if (acc[i]) begin
                    m_full[i] = 1; m_tag[i] = req_tag[i];
                    m_data[i] = req_data[i]; m_rob[i] = req_rob_index[i];
                end else if (g[i]) begin
                    m_full[i] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        chk_cdb_model();
        @(negedge clk);
    endtask

    typedef struct packed {
        bit [NR-1:0]    v;
        bit [NR*TW-1:0] tags;
        bit [NR-1:0]    exp_ready;
        bit [NP-1:0]    exp_cv;
        bit [NP*TW-1:0] exp_tags;
    } vec_t;

    vec_t vecs [4];

    // Producer-side pending results for the random phase
    bit            p_v   [NR];
    logic [TW-1:0] p_tag [NR];
    logic [DW-1:0] p_dat [NR];
    logic [RW-1:0] p_rob [NR];

    initial begin
        // All four producers contend; stalled producers hold, others send fresh tags.
        vecs[0] = '{v: 4'b1111, tags: {6'd4, 6'd3, 6'd2, 6'd1},
                    exp_ready: 4'b1111, exp_cv: 3'b000, exp_tags: 18'd0};
        vecs[1] = '{v: 4'b1111, tags: {6'd20, 6'd19, 6'd18, 6'd17},
                    exp_ready: 4'b0111, exp_cv: 3'b111, exp_tags: {6'd3, 6'd2, 6'd1}};
        vecs[2] = '{v: 4'b1111, tags: {6'd20, 6'd35, 6'd34, 6'd33},
                    exp_ready: 4'b1011, exp_cv: 3'b111, exp_tags: {6'd18, 6'd17, 6'd4}};
        vecs[3] = '{v: 4'b1111, tags: {6'd52, 6'd35, 6'd50, 6'd49},
                    exp_ready: 4'b1101, exp_cv: 3'b111, exp_tags: {6'd33, 6'd20, 6'd19}};

        rst = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 0, 0, '0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < NP; k++) chk("reset cdb_valid", 64'(cdb_valid[k]), 64'd0);
        for (int i = 0; i < NR; i++) chk("reset req_ready", 64'(req_ready[i]), 64'd0);
        rst = 1'b1;

        // Directed contention table
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NR; i++) begin
                int t;
                t = int'(vecs[r].tags[i*TW +: TW]);
                set_req(i, vecs[r].v[i], t, 32'hA500_0000 | DW'(t), t);
            end
            tick();
            for (int i = 0; i < NR; i++)
                chk($sformatf("tbl%0d ready[%0d]", r, i), 64'(obs_ready[i]), 64'(vecs[r].exp_ready[i]));
            for (int k = 0; k < NP; k++) begin
                logic [TW-1:0] et;
                et = vecs[r].exp_tags[k*TW +: TW];
                chk($sformatf("tbl%0d cv[%0d]", r, k), 64'(cdb_valid[k]), 64'(vecs[r].exp_cv[k]));
                chk($sformatf("tbl%0d tag[%0d]", r, k), 64'(cdb_tags[k]), 64'(et));
                if (vecs[r].exp_cv[k])
                    chk($sformatf("tbl%0d data[%0d]", r, k), 64'(cdb_data[k]), 64'(32'hA500_0000 | DW'(et)));
            end
        end

        // Asynchronous reset with all buffers full
        rst = 1'b0;
        #1;
        for (int k = 0; k < NP; k++) chk("async rst cdb_valid", 64'(cdb_valid[k]), 64'd0);
        for (int i = 0; i < NR; i++) chk("async rst req_ready", 64'(req_ready[i]), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk_cdb_model();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 1, i + 1, 32'hC000_0000 + DW'(i), i + 1);
        tick();
        idle();
        tick();
        for (int k = 0; k < NP; k++) chk("post-rst grant order", 64'(cdb_tags[k]), 64'(k + 1));
        repeat (3) tick();

        // Single result from requester 2
        set_req(2, 1, 5, 32'hDEAD_BEEF, 9);
        tick();
        chk("single ready[2] t", 64'(obs_ready[2]), 64'd1);
        chk("single early cdb", 64'(cdb_valid[0]), 64'd0);
        idle();
        tick();
        chk("single ready[2] t+1", 64'(obs_ready[2]), 64'd1);
        chk("single slot0 valid", 64'(cdb_valid[0]), 64'd1);
        chk("single slot0 tag", 64'(cdb_tags[0]), 64'd5);
        chk("single slot0 data", 64'(cdb_data[0]), 64'hDEAD_BEEF);
        chk("single slot0 rob", 64'(cdb_rob_index[0]), 64'd9);
        chk("single slot1 valid", 64'(cdb_valid[1]), 64'd0);
        chk("single slot2 valid", 64'(cdb_valid[2]), 64'd0);
        tick();

        // Back-to-back results from requester 1, no bubble
        for (int n = 0; n < 4; n++) begin
            if (n < 3) set_req(1, 1, 10 + n, 32'h0000_0100 + DW'(n), 20 + n);
            else idle();
            tick();
            if (n > 0) begin
                chk("b2b valid", 64'(cdb_valid[0]), 64'd1);
                chk("b2b tag", 64'(cdb_tags[0]), 64'(10 + n - 1));
            end
        end
        tick();
        chk("b2b drained", 64'(cdb_valid[0]), 64'd0);

        // Flush with buffers 0 and 3 full and a new result on requester 1
        set_req(0, 1, 40, 32'h40, 40);
        set_req(3, 1, 43, 32'h43, 43);
        tick();
        idle();
        flush = 1'b1;
        set_req(1, 1, 41, 32'h41, 41);
        tick();
        chk("flush ready[1]", 64'(obs_ready[1]), 64'd0);
        for (int k = 0; k < NP; k++) chk("flush cdb_valid", 64'(cdb_valid[k]), 64'd0);
        flush = 1'b0;
        idle();
        tick();
        for (int k = 0; k < NP; k++) chk("flush dropped", 64'(cdb_valid[k]), 64'd0);
        for (int i = 0; i < NR; i++) set_req(i, 1, 50 + i, 32'h50 + DW'(i), i);
        tick();
        idle();
        tick();
        for (int k = 0; k < NP; k++) chk("post-flush order", 64'(cdb_tags[k]), 64'(50 + k));
        tick();
        chk("post-flush loser", 64'(cdb_tags[0]), 64'd53);

        // Tag 0 result still broadcasts
        set_req(3, 1, 0, 32'h1234, 17);
        tick();
        idle();
        tick();
        chk("tag0 valid", 64'(cdb_valid[0]), 64'd1);
        chk("tag0 tag", 64'(cdb_tags[0]), 64'd0);
        chk("tag0 rob", 64'(cdb_rob_index[0]), 64'd17);
        tick();

        // Randomized traffic; producers hold results until accepted
        for (int i = 0; i < NR; i++) begin
            p_v[i] = 0; p_tag[i] = '0; p_dat[i] = '0; p_rob[i] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!p_v[i] && $urandom_range(0, 3) != 0) begin
                    p_v[i]   = 1;
                    p_tag[i] = TW'($urandom);
                    p_dat[i] = $urandom;
                    p_rob[i] = RW'($urandom);
                end
                set_req(i, p_v[i], int'(p_tag[i]), p_dat[i], int'(p_rob[i]));
            end
            flush = ($urandom_range(0, 24) == 0);
            tick();
            for (int i = 0; i < NR; i++)
                if (p_v[i] && (obs_ready[i] || flush)) p_v[i] = 0;
            flush = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
